// File: rtl/pool_addr_gen_pkg.sv
// Shared types and width helper for the pooled-feature buffer address generator.
package pool_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } pool_state_e;

  // Address field width; never below one bit so single-entry dimensions still have a port.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_addr_gen_lane_ctr.sv
// One write lane's (row, col) entry counter: advances by LANES entries per accepted
// beat, reloads to (row 0, col LANE_IDX), and flags the lane valid while row < ROWS.
module pool_lane_ctr #(
  parameter int COLS     = 7,
  parameter int ROWS     = 28,
  parameter int LANES    = 4,
  parameter int LANE_IDX = 0,
  parameter int COL_W    = 3,
  parameter int ROW_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_reload,
  input  logic             i_adv,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_en
);

  // One spare row bit lets the counter step past the last row, which disables the lane.
  localparam int IROW_W = ROW_W + 1;
  localparam logic [COL_W-1:0] COL_INIT = COL_W'(LANE_IDX);

  logic [COL_W-1:0]  r_col;
  logic [IROW_W-1:0] r_row;
  logic [COL_W:0]    w_col_sum;
  logic [COL_W:0]    w_col_wrapped;
  logic              w_wrap;

  assign w_col_sum     = {1'b0, r_col} + (COL_W+1)'(LANES);
  assign w_wrap        = (w_col_sum >= (COL_W+1)'(COLS));
  assign w_col_wrapped = w_col_sum - (COL_W+1)'(COLS);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= COL_INIT;
      r_row <= '0;
    end else if (i_reload) begin
      r_col <= COL_INIT;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_wrap) begin
        r_col <= w_col_wrapped[COL_W-1:0];
        r_row <= r_row + IROW_W'(1);
      end else begin
        r_col <= w_col_sum[COL_W-1:0];
      end
    end
  end

  assign o_en  = (r_row < IROW_W'(ROWS));
  assign o_col = o_en ? r_col : '0;
  assign o_row = o_en ? r_row[ROW_W-1:0] : '0;

endmodule

// File: rtl/pool_addr_gen.sv
// Pooled-buffer address generator: LANES write addresses per beat in row-major order,
// then a row-offset read stream. Optional sticky protocol-error flag: POOL_OVF_DETECT_EN.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int COLS  = 7,
  parameter int ROWS  = 28,
  parameter int LANES = 4,
  parameter int COL_W = addr_w(COLS),
  parameter int ROW_W = addr_w(ROWS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  output logic [LANES*COL_W-1:0] o_wr_col,
  output logic [LANES*ROW_W-1:0] o_wr_row,
  output logic [LANES-1:0]       o_wr_lane_en,
  output logic                   o_wr_done,
  input  logic                   i_rd_en,
  output logic                   o_rd_valid,
  output logic [ROW_W-1:0]       o_rd_row,
  output logic                   o_rd_last,
  output logic                   o_full,
  output logic                   o_ovf,
  output logic [1:0]             o_state
);

  // Handshakes: a write beat transfers when i_wr_valid && o_wr_ready; a read row
  // transfers when o_rd_valid (i_rd_en while holding data). i_clear overrides both.

  pool_state_e      r_state;
  pool_state_e      w_state_nxt;
  logic             w_wr_ready;
  logic             w_wr_acc;
  logic             w_rd_valid;
  logic             w_last;
  logic             w_reload;
  logic [LANES-1:0] w_lane_last;
  logic             r_wr_done;
  logic [ROW_W-1:0] r_rd_row;
  logic [ROW_W-1:0] w_rd_row_nxt;
  logic             r_rd_at_last;

  assign w_wr_ready = (r_state == EMPTY) || (r_state == WRITE);
  assign w_wr_acc   = i_wr_valid && w_wr_ready && !i_clear;
  assign w_rd_valid = i_rd_en && ((r_state == FULL) || (r_state == READ)) && !i_clear;
  assign w_last     = |w_lane_last;
  assign w_reload   = i_clear || (w_wr_acc && w_last);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pool_lane_ctr #(
      .COLS    (COLS),
      .ROWS    (ROWS),
      .LANES   (LANES),
      .LANE_IDX(k),
      .COL_W   (COL_W),
      .ROW_W   (ROW_W)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_reload(w_reload),
      .i_adv   (w_wr_acc),
      .o_col   (o_wr_col[k*COL_W +: COL_W]),
      .o_row   (o_wr_row[k*ROW_W +: ROW_W]),
      .o_en    (o_wr_lane_en[k])
    );

    // The beat holding the final entry is the one where some live lane sits on it.
    assign w_lane_last[k] = o_wr_lane_en[k]
                         && (o_wr_row[k*ROW_W +: ROW_W] == ROW_W'(ROWS-1))
                         && (o_wr_col[k*COL_W +: COL_W] == COL_W'(COLS-1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_wr_acc) w_state_nxt = w_last ? FULL : WRITE;
      WRITE: if (w_wr_acc && w_last) w_state_nxt = FULL;
      FULL:  if (w_rd_valid) w_state_nxt = r_rd_at_last ? EMPTY : READ;
      READ:  if (w_rd_valid && r_rd_at_last) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
    if (i_clear) w_state_nxt = EMPTY;
  end

  assign w_rd_row_nxt = r_rd_at_last ? '0 : (r_rd_row + ROW_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= EMPTY;
      r_wr_done    <= 1'b0;
      r_rd_row     <= '0;
      r_rd_at_last <= (ROWS == 1);
    end else begin
      r_state   <= w_state_nxt;
      r_wr_done <= w_wr_acc && w_last;
      if (i_clear) begin
        r_rd_row     <= '0;
        r_rd_at_last <= (ROWS == 1);
      end else if (w_rd_valid) begin
        r_rd_row     <= w_rd_row_nxt;
        r_rd_at_last <= (w_rd_row_nxt == ROW_W'(ROWS-1));
      end
    end
  end

`ifdef POOL_OVF_DETECT_EN
  logic r_ovf;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_ovf <= 1'b0;
    end else if ((i_wr_valid && !w_wr_ready) || (i_rd_en && w_wr_ready)) begin
      r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign o_ovf = 1'b0;
`endif

  assign o_wr_ready = w_wr_ready;
  assign o_wr_done  = r_wr_done;
  assign o_rd_valid = w_rd_valid;
  assign o_rd_row   = r_rd_row;
  assign o_rd_last  = w_rd_valid && r_rd_at_last;
  assign o_full     = (r_state == FULL);
  assign o_state    = r_state;

endmodule

// File: tb/tb_pool_addr_gen.sv
// Bench for pool_addr_gen: directed checks plus randomized traffic against an
// entry-arithmetic reference model; a second small instance covers the partial last beat.
module tb_pool_addr_gen;
  import pool_pkg::*;

  localparam int COLS  = 7;
  localparam int ROWS  = 28;
  localparam int LANES = 4;
  localparam int TOTAL = COLS * ROWS;
  localparam int BEATS = (TOTAL + LANES - 1) / LANES;
  localparam int COL_W = addr_w(COLS);
  localparam int ROW_W = addr_w(ROWS);

  localparam int B_COLS  = 7;
  localparam int B_ROWS  = 3;
  localparam int B_COL_W = addr_w(B_COLS);
  localparam int B_ROW_W = addr_w(B_ROWS);

`ifdef POOL_OVF_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic                   a_clear, a_wr_valid, a_rd_en;
  logic                   a_wr_ready, a_wr_done, a_rd_valid, a_rd_last, a_full, a_ovf;
  logic [LANES*COL_W-1:0] a_wr_col;
  logic [LANES*ROW_W-1:0] a_wr_row;
  logic [LANES-1:0]       a_wr_lane_en;
  logic [ROW_W-1:0]       a_rd_row;
  logic [1:0]             a_state;

  pool_addr_gen #(.COLS(COLS), .ROWS(ROWS), .LANES(LANES)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(a_clear), .i_wr_valid(a_wr_valid),
    .o_wr_ready(a_wr_ready), .o_wr_col(a_wr_col), .o_wr_row(a_wr_row),
    .o_wr_lane_en(a_wr_lane_en), .o_wr_done(a_wr_done), .i_rd_en(a_rd_en),
    .o_rd_valid(a_rd_valid), .o_rd_row(a_rd_row), .o_rd_last(a_rd_last),
    .o_full(a_full), .o_ovf(a_ovf), .o_state(a_state)
  );

  // instance B
  logic                     b_clear, b_wr_valid, b_rd_en;
  logic                     b_wr_ready, b_wr_done, b_rd_valid, b_rd_last, b_full, b_ovf;
  logic [LANES*B_COL_W-1:0] b_wr_col;
  logic [LANES*B_ROW_W-1:0] b_wr_row;
  logic [LANES-1:0]         b_wr_lane_en;
  logic [B_ROW_W-1:0]       b_rd_row;
  logic [1:0]               b_state;

  pool_addr_gen #(.COLS(B_COLS), .ROWS(B_ROWS), .LANES(LANES)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(b_clear), .i_wr_valid(b_wr_valid),
    .o_wr_ready(b_wr_ready), .o_wr_col(b_wr_col), .o_wr_row(b_wr_row),
    .o_wr_lane_en(b_wr_lane_en), .o_wr_done(b_wr_done), .i_rd_en(b_rd_en),
    .o_rd_valid(b_rd_valid), .o_rd_row(b_rd_row), .o_rd_last(b_rd_last),
    .o_full(b_full), .o_ovf(b_ovf), .o_state(b_state)
  );

  // scoreboard counters and checker
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: beats accepted, buffer holding data, read progress
  int m_beat, m_rd;
  bit m_full, m_reading, m_done, m_ovf;

  task automatic model_reset();
    m_beat = 0; m_rd = 0; m_full = 0; m_reading = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic check_model();
    int b, e;
    logic [31:0] exp_st;
    bit en;
    b = m_full ? 0 : m_beat;
    for (int k = 0; k < LANES; k++) begin
      e  = b * LANES + k;
      en = (e < TOTAL);
      check($sformatf("lane%0d_en", k), 32'(a_wr_lane_en[k]), 32'(en));
      check($sformatf("lane%0d_col", k), 32'(a_wr_col[k*COL_W +: COL_W]), en ? e % COLS : 0);
      check($sformatf("lane%0d_row", k), 32'(a_wr_row[k*ROW_W +: ROW_W]), en ? e / COLS : 0);
    end
    if (m_full) exp_st = m_reading ? 32'(READ) : 32'(FULL);
    else        exp_st = (m_beat == 0) ? 32'(EMPTY) : 32'(WRITE);
    check("state",    32'(a_state),    exp_st);
    check("wr_ready", 32'(a_wr_ready), 32'(!m_full));
    check("full",     32'(a_full),     32'(m_full && !m_reading));
    check("wr_done",  32'(a_wr_done),  32'(m_done));
    check("rd_valid", 32'(a_rd_valid), 32'(a_rd_en && m_full && !a_clear));
    check("rd_row",   32'(a_rd_row),   32'(m_rd));
    check("rd_last",  32'(a_rd_last),  32'(a_rd_en && m_full && !a_clear && m_rd == ROWS-1));
    check("ovf",      32'(a_ovf),      32'(OVF_EN && m_ovf));
  endtask

  task automatic model_update();
    m_done = 0;
    if (a_clear) begin
      model_reset();
    end else begin
      if ((a_wr_valid && m_full) || (a_rd_en && !m_full)) m_ovf = 1;
      if (a_rd_en && m_full) begin
        m_reading = 1;
        if (m_rd == ROWS-1) begin
          m_rd = 0; m_full = 0; m_reading = 0;
        end else begin
          m_rd++;
        end
      end else if (a_wr_valid && !m_full) begin
        m_beat++;
        if (m_beat == BEATS) begin
          m_full = 1; m_beat = 0; m_done = 1;
        end
      end
    end
  endtask

  // driver: one cycle on instance A, checked against the model before the edge
  task automatic step(input bit wv, input bit re, input bit clr);
    @(negedge clk);
    a_wr_valid = wv; a_rd_en = re; a_clear = clr;
    #1;
    check_model();
    @(posedge clk);
    model_update();
    #1;
    a_wr_valid = 0; a_rd_en = 0; a_clear = 0;
  endtask

  task automatic b_beat();
    @(negedge clk);
    b_wr_valid = 1;
    @(posedge clk);
    #1;
    b_wr_valid = 0;
  endtask

  initial begin
    a_clear = 0; a_wr_valid = 0; a_rd_en = 0;
    b_clear = 0; b_wr_valid = 0; b_rd_en = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;

    // reset values
    for (int k = 0; k < LANES; k++) begin
      check("rst_col", 32'(a_wr_col[k*COL_W +: COL_W]), k);
      check("rst_row", 32'(a_wr_row[k*ROW_W +: ROW_W]), 0);
    end
    check("rst_wr_ready", 32'(a_wr_ready), 1);
    check("rst_full",     32'(a_full),     0);
    check("rst_lane_en",  32'(a_wr_lane_en), 32'hF);

    // second beat addressing
    step(1, 0, 0);
    check("b1_l0_col", 32'(a_wr_col[0 +: COL_W]), 4);
    check("b1_l0_row", 32'(a_wr_row[0 +: ROW_W]), 0);
    check("b1_l3_col", 32'(a_wr_col[3*COL_W +: COL_W]), 0);
    check("b1_l3_row", 32'(a_wr_row[3*ROW_W +: ROW_W]), 1);

    // fill to the last beat
    repeat (BEATS - 2) step(1, 0, 0);
    check("pre_full", 32'(a_full), 0);
    check("pre_ready", 32'(a_wr_ready), 1);
    step(1, 0, 0);
    check("full_set", 32'(a_full), 1);
    check("done_set", 32'(a_wr_done), 1);
    check("ready_drop", 32'(a_wr_ready), 0);

    // write attempt while full
    step(1, 0, 0);
    check("ovf_wr_full", 32'(a_ovf), 32'(OVF_EN));
    check("full_hold", 32'(a_full), 1);
    check("done_pulse", 32'(a_wr_done), 0);
    check("hold_l0_col", 32'(a_wr_col[0 +: COL_W]), 0);
    check("hold_l1_col", 32'(a_wr_col[COL_W +: COL_W]), 1);

    // read with a pause at row 10
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check("pause_row", 32'(a_rd_row), 10);
    repeat (5) step(0, 0, 0);
    check("pause_hold", 32'(a_rd_row), 10);
    check("pause_state", 32'(a_state), 32'(READ));
    for (int i = 10; i < ROWS; i++) step(0, 1, 0);
    check("rd_done_state", 32'(a_state), 32'(EMPTY));
    check("rd_done_ready", 32'(a_wr_ready), 1);

    // clear mid-fill
    repeat (3) step(1, 0, 0);
    step(0, 0, 1);
    check("clr_state", 32'(a_state), 32'(EMPTY));
    check("clr_ovf", 32'(a_ovf), 0);
    check("clr_l2_col", 32'(a_wr_col[2*COL_W +: COL_W]), 2);
    check("clr_l2_row", 32'(a_wr_row[2*ROW_W +: ROW_W]), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit wv, re, clr;
      clr = ($urandom_range(0, 299) == 0);
      if (m_full) begin
        wv = ($urandom_range(0, 7) == 0);
        re = ($urandom_range(0, 3) != 0);
      end else begin
        wv = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 15) == 0);
      end
      step(wv, re, clr);
    end

    // instance B: partial final beat
    check("b_rst_en", 32'(b_wr_lane_en), 32'hF);
    repeat (5) b_beat();
    check("b_b5_en", 32'(b_wr_lane_en), 32'h1);
    check("b_b5_l0_col", 32'(b_wr_col[0 +: B_COL_W]), 6);
    check("b_b5_l0_row", 32'(b_wr_row[0 +: B_ROW_W]), 2);
    check("b_b5_hi_col", 32'(b_wr_col[LANES*B_COL_W-1:B_COL_W]), 0);
    check("b_b5_hi_row", 32'(b_wr_row[LANES*B_ROW_W-1:B_ROW_W]), 0);
    check("b_b5_full", 32'(b_full), 0);
    b_beat();
    check("b_full", 32'(b_full), 1);
    check("b_done", 32'(b_wr_done), 1);
    for (int i = 0; i < B_ROWS; i++) begin
      @(negedge clk);
      b_rd_en = 1;
      #1;
      check("b_rd_valid", 32'(b_rd_valid), 1);
      check("b_rd_row", 32'(b_rd_row), i);
      check("b_rd_last", 32'(b_rd_last), 32'(i == B_ROWS-1));
      @(posedge clk);
      #1;
      b_rd_en = 0;
    end
    check("b_end_ready", 32'(b_wr_ready), 1);
    check("b_end_state", 32'(b_state), 32'(EMPTY));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pool_addr_gen.md
# pool_addr_gen

Parametrised address generator for the pooled-feature buffer, placed between the max-pool stage and the pooled-output RAM. Each accepted write beat produces a write address per lane for LANES pooled values, filling a COLS×ROWS buffer in row-major order with a partial-beat lane mask. A row-offset stream is then produced for the next layer, and the buffer is tracked as EMPTY, WRITE, FULL or READ so writes and reads never overlap.

## Interface
- COLS, 7, columns per buffer row; 1 ≤ LANES ≤ COLS
- ROWS, 28, buffer rows
- LANES, 4, write lanes per beat
- COL_W, $clog2(COLS), column address width
- ROW_W, $clog2(ROWS), row address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- clear  in  1  synchronous abort; returns to EMPTY, same values as reset
- wr_valid  in  1  pooled beat present
- wr_ready  out  1  high in EMPTY or WRITE
- wr_col  out  LANES*COL_W  lane k column at [k*COL_W +: COL_W]
- wr_row  out  LANES*ROW_W  lane k row at [k*ROW_W +: ROW_W]
- wr_lane_en  out  LANES  lane k address valid this beat
- wr_done  out  1  one-cycle pulse, cycle after the final beat is accepted
- rd_en  in  1  consumer requests next row
- rd_valid  out  1  rd_row valid this cycle
- rd_row  out  ROW_W  row offset being read
- rd_last  out  1  rd_valid on row ROWS-1
- full  out  1  high in FULL
- ovf  out  1  sticky protocol-error flag (see Configuration)

## Operation
- TOTAL = COLS*ROWS entries; BEATS = ceil(TOTAL/LANES).
- States: EMPTY → WRITE on first accepted beat; WRITE → FULL on accepted beat covering entry TOTAL-1; FULL → READ on first rd_valid; READ → EMPTY on accepted rd_last. A one-beat fill (TOTAL ≤ LANES) goes EMPTY → FULL directly.
- Lane k of beat b addresses entry b*LANES+k: row = entry/COLS, col = entry%COLS.
- Per-lane counters hold (row, col) with one extra internal row bit. On an accepted beat: col += LANES; if col ≥ COLS then col -= COLS, row += 1. Only one wrap is needed because LANES ≤ COLS.
- wr_lane_en[k] = internal row[k] < ROWS. Disabled lanes drive wr_col/wr_row = 0.
- On entering FULL, the lane counters reload: col = k, row = 0.
- rd_valid = rd_en && (FULL || READ). On rd_valid, rd_row increments; at ROWS-1 it wraps to 0.
- rd_en low in READ pauses: rd_row holds and the state does not change.
- wr_valid while wr_ready = 0 is ignored, and rd_en in EMPTY or WRITE is ignored. Both record ovf when the feature is enabled.
- clear has priority over wr_valid and rd_en in the same cycle.

## Timing
- Reset/clear values: state EMPTY; lane k col = k, row = 0; wr_ready 1; wr_lane_en all 1 when TOTAL ≥ LANES; wr_done 0; rd_row 0; rd_valid 0; rd_last 0; full 0; ovf 0.
- Write addresses come directly from registers and are valid in the same cycle as wr_ready. Counters advance at the edge that accepts the beat.
- wr_done and full assert at the edge after the last beat. wr_ready drops in that same cycle.
- rd_valid is combinational from rd_en, with zero latency. rd_row and rd_last come from registers.
- After rd_last is accepted, wr_ready = 1 in the next cycle.
- Back-to-back beats give one beat per cycle, so a full fill takes exactly BEATS accepted cycles.

## Configuration
- POOL_OVF_DETECT_EN defined:
  - ovf sets on wr_valid && !wr_ready.
  - ovf sets on rd_en while in EMPTY or WRITE.
  - ovf clears only on reset or clear.
- POOL_OVF_DETECT_EN undefined: ovf is tied to 0 and the detection logic is not compiled.

## Structure
- Package pool_pkg:
  - pool_state_e enum (EMPTY, WRITE, FULL, READ)
  - width helper function for COL_W and ROW_W
- Sub-module pool_lane_ctr: one lane's (row, col) counter with wrap, reload-to-k and lane-enable output. It is instantiated LANES times by generate.
- The top level holds the FSM, the read counter and the ovf logic.

## Test plan
- Reset with COLS=7, ROWS=28, LANES=4 → wr_col lanes {0,1,2,3}, rows 0, wr_ready 1, full 0.
- Second beat → lane0 (row 0, col 4), lane3 (row 1, col 0). The 49th beat → full 1 and wr_done pulse, with 49 beats total.
- COLS=7, ROWS=3, LANES=4 → 6 beats. Beat 5 gives wr_lane_en = 0001 and lane0 (row 2, col 6). Lanes 1–3 drive 0.
- FULL with rd_en held for 28 cycles → rd_row 0..27, rd_last on 27 only, then EMPTY and wr_ready 1.
- rd_en low for 5 cycles mid-read at rd_row 10 → rd_row holds 10 and resumes at 11.
- POOL_OVF_DETECT_EN with wr_valid in FULL → ovf 1, counters unchanged. A clear pulse → EMPTY, ovf 0, reset values restored.
